// File: rtl/ultrasonic.sv
// ---------------------------------------------------------------------------
// ultrasonic -- water-tank level controller driven by an ultrasonic sensor.
//
// The raw 2-bit level code from the sensor is debounced. The debounced level
// then drives a two-state pump FSM with hysteresis: it starts filling at empty
// or low and stops at full. Two indicator LEDs are decoded from the level and
// the pump state. A registered buzzer gives an empty alarm and a short chirp
// each time the tank becomes full.
//
// Optional feature, enabled by defining the macro ULTRASONIC_DRYRUN_EN:
//   a dry-run watchdog. If the pump runs for MAX_RUN clocks without the level
//   rising, the FSM enters a FAULT lockout that only reset can clear.
//
// Parameters
//   DEBOUNCE     1..15     consecutive equal samples needed to accept a level
//   BEEP_CYCLES  1..255    length of the full-tank chirp in clocks
//   MAX_RUN      2..65535  dry-run timeout in clocks (watchdog build only)
//
// Ports
//   clk     in   single clock, rising edge
//   rst_n   in   synchronous active-low reset
//   i       in   [1:0] raw level code: 00 empty, 01 low, 10 mid, 11 full
//   level   out  [1:0] debounced level code
//   motor   out  [1:0] 00 off, 01 running, 10 fault lockout
//   led     out  [1:0] led[1] tank full, led[0] pump running
//   buzzer  out  [1:0] 00 silent, 01 empty alarm, 10 full chirp, 11 fault
// ---------------------------------------------------------------------------
module ultrasonic #(
  parameter int DEBOUNCE    = 2,
  parameter int BEEP_CYCLES = 8,
  parameter int MAX_RUN     = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i,
  output logic [1:0] level,
  output logic [1:0] motor,
  output logic [1:0] led,
  output logic [1:0] buzzer
);

  // The state codes match the motor encoding.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_FILL  = 2'b01;
`ifdef ULTRASONIC_DRYRUN_EN
  localparam logic [1:0] ST_FAULT = 2'b10;
`endif

  localparam logic [1:0] LVL_EMPTY = 2'b00;
  localparam logic [1:0] LVL_FULL  = 2'b11;

  logic [1:0] i_q;
  logic [3:0] stab_q, stab_d;
  logic [4:0] run_len;
  logic [1:0] level_q, level_d;
  logic [7:0] beep_q, beep_d;
  logic [1:0] buzzer_q, buzzer_d;
  logic [1:0] state_q, state_d;

`ifdef ULTRASONIC_DRYRUN_EN
  logic [15:0] run_q, run_d;
  logic        level_inc;
  logic        run_hit;
`endif

  // -------------------------------------------------------------------------
  // Debounce
  // run_len is the length of the current run of equal samples, counting the
  // sample taken on this edge. The stored count saturates so a long steady
  // input cannot wrap back below DEBOUNCE.
  // -------------------------------------------------------------------------
  always_comb begin
    run_len = (i == i_q) ? ({1'b0, stab_q} + 5'd1) : 5'd1;
    stab_d  = (run_len > 5'd15) ? 4'd15 : run_len[3:0];
    level_d = level_q;
    if ((run_len >= 5'(DEBOUNCE)) && (i != level_q)) begin
      level_d = i;
    end
  end

  // -------------------------------------------------------------------------
  // Chirp counter: armed only on a transition into full, so staying full does
  // not retrigger it. Leaving full cancels any chirp still in progress.
  // -------------------------------------------------------------------------
  always_comb begin
    beep_d = beep_q;
    if ((level_d == LVL_FULL) && (level_q != LVL_FULL)) begin
      beep_d = 8'(BEEP_CYCLES);
    end else if (level_d != LVL_FULL) begin
      beep_d = 8'd0;
    end else if (beep_q != 8'd0) begin
      beep_d = beep_q - 8'd1;
    end
  end

`ifdef ULTRASONIC_DRYRUN_EN
  // -------------------------------------------------------------------------
  // Dry-run watchdog: counts pump clocks since the level last rose. Any rise
  // proves water is arriving and restarts the count.
  // -------------------------------------------------------------------------
  always_comb begin
    level_inc = (level_d > level_q);
    run_hit   = (state_q == ST_FILL) && !level_inc && (run_q == 16'(MAX_RUN - 1));
    run_d     = run_q + 16'd1;
    if ((state_q != ST_FILL) || level_inc) begin
      run_d = 16'd0;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Pump FSM: next-state logic. A mid level holds the current state, which
  // gives the fill/stop hysteresis.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (level_q[1] == 1'b0) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (level_q == LVL_FULL) begin
          state_d = ST_IDLE;
        end
`ifdef ULTRASONIC_DRYRUN_EN
        else if (run_hit) begin
          state_d = ST_FAULT;
        end
`endif
      end
`ifdef ULTRASONIC_DRYRUN_EN
      ST_FAULT: state_d = ST_FAULT;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // The buzzer follows the next state, so the fault alarm starts on the same
  // edge as the motor lockout.
  always_comb begin
    buzzer_d = 2'b00;
`ifdef ULTRASONIC_DRYRUN_EN
    if (state_d == ST_FAULT) begin
      buzzer_d = 2'b11;
    end else
`endif
    if (beep_q != 8'd0) begin
      buzzer_d = 2'b10;
    end else if (level_q == LVL_EMPTY) begin
      buzzer_d = 2'b01;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_q      <= 2'b00;
      stab_q   <= 4'd0;
      level_q  <= 2'b00;
      beep_q   <= 8'd0;
      buzzer_q <= 2'b00;
      state_q  <= ST_IDLE;
`ifdef ULTRASONIC_DRYRUN_EN
      run_q    <= 16'd0;
`endif
    end else begin
      i_q      <= i;
      stab_q   <= stab_d;
      level_q  <= level_d;
      beep_q   <= beep_d;
      buzzer_q <= buzzer_d;
      state_q  <= state_d;
`ifdef ULTRASONIC_DRYRUN_EN
      run_q    <= run_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Pump FSM: output decode
  // -------------------------------------------------------------------------
  always_comb begin
    motor = 2'b00;
    case (state_q)
      ST_FILL:  motor = 2'b01;
`ifdef ULTRASONIC_DRYRUN_EN
      ST_FAULT: motor = 2'b10;
`endif
      default:  motor = 2'b00;
    endcase
  end

  assign level  = level_q;
  assign buzzer = buzzer_q;
  assign led    = {(level_q == LVL_FULL), (motor == 2'b01)};

endmodule

// File: tb/tb_ultrasonic.sv
// ---------------------------------------------------------------------------
// tb_ultrasonic -- directed self-checking bench for ultrasonic.
// Inputs change 1 ns after a rising edge and outputs are sampled there too,
// well away from the next active edge. The watchdog scenario is selected by
// the same macro as the design.
// ---------------------------------------------------------------------------
module tb_ultrasonic;

  logic       clk;
  logic       rst_n;
  logic [1:0] i;
  logic [1:0] level;
  logic [1:0] motor;
  logic [1:0] led;
  logic [1:0] buzzer;

  int tests_run;
  int tests_failed;

  ultrasonic #(
    .DEBOUNCE   (2),
    .BEEP_CYCLES(8),
    .MAX_RUN    (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (i),
    .level (level),
    .motor (motor),
    .led   (led),
    .buzzer(buzzer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    i     = 2'b00;
    step(2);
    tests_run++; if (level !== 2'b00) begin tests_failed++; $display("FAIL reset_level: got %b expected 00", level); end
    tests_run++; if (motor !== 2'b00) begin tests_failed++; $display("FAIL reset_motor: got %b expected 00", motor); end
    tests_run++; if (buzzer !== 2'b00) begin tests_failed++; $display("FAIL reset_buzzer: got %b expected 00", buzzer); end
    tests_run++; if (led !== 2'b00) begin tests_failed++; $display("FAIL reset_led: got %b expected 00", led); end
    $display("[TB] reset: level=%b motor=%b buzzer=%b led=%b", level, motor, buzzer, led);
  endtask

  // Empty tank after reset: pump starts one edge later, empty alarm sounds.
  task automatic test_startup;
    rst_n = 1'b1;
    step(1);
    tests_run++; if (level !== 2'b00) begin tests_failed++; $display("FAIL start_level: got %b expected 00", level); end
    tests_run++; if (motor !== 2'b01) begin tests_failed++; $display("FAIL start_motor: got %b expected 01", motor); end
    tests_run++; if (buzzer !== 2'b01) begin tests_failed++; $display("FAIL start_buzzer: got %b expected 01", buzzer); end
    tests_run++; if (led !== 2'b01) begin tests_failed++; $display("FAIL start_led: got %b expected 01", led); end
    $display("[TB] startup: level=%b motor=%b buzzer=%b led=%b", level, motor, buzzer, led);
  endtask

  // Fill to full and measure the chirp length.
  task automatic test_fill;
    int beeps;
    i = 2'b01;
    step(1);
    tests_run++; if (level !== 2'b00) begin tests_failed++; $display("FAIL debounce_latency: got %b expected 00", level); end
    step(1);
    tests_run++; if (level !== 2'b01) begin tests_failed++; $display("FAIL debounce_accept: got %b expected 01", level); end
    step(3);
    tests_run++; if (motor !== 2'b01) begin tests_failed++; $display("FAIL fill_low_motor: got %b expected 01", motor); end
    tests_run++; if (buzzer !== 2'b00) begin tests_failed++; $display("FAIL fill_low_buzzer: got %b expected 00", buzzer); end
    i = 2'b10;
    step(5);
    tests_run++; if (level !== 2'b10) begin tests_failed++; $display("FAIL fill_mid_level: got %b expected 10", level); end
    tests_run++; if (motor !== 2'b01) begin tests_failed++; $display("FAIL fill_mid_motor: got %b expected 01", motor); end
    i = 2'b11;
    step(2);
    tests_run++; if (level !== 2'b11) begin tests_failed++; $display("FAIL full_level: got %b expected 11", level); end
    tests_run++; if (motor !== 2'b01) begin tests_failed++; $display("FAIL full_motor_lag: got %b expected 01", motor); end
    step(1);
    tests_run++; if (motor !== 2'b00) begin tests_failed++; $display("FAIL full_motor_stop: got %b expected 00", motor); end
    tests_run++; if (led !== 2'b10) begin tests_failed++; $display("FAIL full_led: got %b expected 10", led); end
    tests_run++; if (buzzer !== 2'b10) begin tests_failed++; $display("FAIL chirp_start: got %b expected 10", buzzer); end
    beeps = 1;
    for (int k = 0; k < 11; k++) begin
      step(1);
      if (buzzer == 2'b10) beeps++;
    end
    tests_run++; if (beeps != 8) begin tests_failed++; $display("FAIL chirp_length: got %0d expected 8", beeps); end
    tests_run++; if (buzzer !== 2'b00) begin tests_failed++; $display("FAIL chirp_end: got %b expected 00", buzzer); end
    $display("[TB] fill: level=%b motor=%b led=%b chirp=%0d clocks", level, motor, led, beeps);
  endtask

  // One-clock dip to mid while full must be filtered out.
  task automatic test_glitch;
    i = 2'b10;
    step(1);
    i = 2'b11;
    step(1);
    tests_run++; if (level !== 2'b11) begin tests_failed++; $display("FAIL glitch_level: got %b expected 11", level); end
    step(3);
    tests_run++; if (level !== 2'b11) begin tests_failed++; $display("FAIL glitch_level_late: got %b expected 11", level); end
    tests_run++; if (motor !== 2'b00) begin tests_failed++; $display("FAIL glitch_motor: got %b expected 00", motor); end
    tests_run++; if (buzzer !== 2'b00) begin tests_failed++; $display("FAIL glitch_no_rechirp: got %b expected 00", buzzer); end
    $display("[TB] glitch: level=%b motor=%b buzzer=%b", level, motor, buzzer);
  endtask

  // Draining to mid keeps the pump off; reaching low restarts it.
  task automatic test_hysteresis;
    i = 2'b10;
    step(4);
    tests_run++; if (level !== 2'b10) begin tests_failed++; $display("FAIL hyst_level: got %b expected 10", level); end
    tests_run++; if (motor !== 2'b00) begin tests_failed++; $display("FAIL hyst_motor_hold: got %b expected 00", motor); end
    i = 2'b01;
    step(2);
    tests_run++; if (level !== 2'b01) begin tests_failed++; $display("FAIL hyst_low_level: got %b expected 01", level); end
    tests_run++; if (motor !== 2'b00) begin tests_failed++; $display("FAIL hyst_motor_lag: got %b expected 00", motor); end
    step(1);
    tests_run++; if (motor !== 2'b01) begin tests_failed++; $display("FAIL hyst_motor_start: got %b expected 01", motor); end
    $display("[TB] hysteresis: level=%b motor=%b", level, motor);
  endtask

  // Re-entering full restarts the chirp; staying full does not.
  task automatic test_retrigger;
    int beeps;
    i = 2'b11;
    step(2);
    beeps = 0;
    for (int k = 0; k < 12; k++) begin
      step(1);
      if (buzzer == 2'b10) beeps++;
    end
    tests_run++; if (beeps != 8) begin tests_failed++; $display("FAIL rechirp_length: got %0d expected 8", beeps); end
    beeps = 0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (buzzer != 2'b00) beeps++;
    end
    tests_run++; if (beeps != 0) begin tests_failed++; $display("FAIL steady_full_silent: got %0d noisy clocks expected 0", beeps); end
    $display("[TB] retrigger: chirp done, level=%b buzzer=%b", level, buzzer);
  endtask

`ifdef ULTRASONIC_DRYRUN_EN
  // Level held empty while pumping: lockout after 16 clocks in FILL.
  task automatic test_dryrun;
    i = 2'b00;
    step(18);
    tests_run++; if (motor !== 2'b01) begin tests_failed++; $display("FAIL dry_before_timeout: got %b expected 01", motor); end
    step(1);
    tests_run++; if (motor !== 2'b10) begin tests_failed++; $display("FAIL dry_fault_motor: got %b expected 10", motor); end
    tests_run++; if (buzzer !== 2'b11) begin tests_failed++; $display("FAIL dry_fault_buzzer: got %b expected 11", buzzer); end
    tests_run++; if (led !== 2'b00) begin tests_failed++; $display("FAIL dry_fault_led: got %b expected 00", led); end
    i = 2'b11;
    step(5);
    tests_run++; if (motor !== 2'b10) begin tests_failed++; $display("FAIL fault_sticky_motor: got %b expected 10", motor); end
    tests_run++; if (buzzer !== 2'b11) begin tests_failed++; $display("FAIL fault_sticky_buzzer: got %b expected 11", buzzer); end
    $display("[TB] dryrun: motor=%b buzzer=%b led=%b", motor, buzzer, led);
  endtask
`else
  // Without the watchdog the pump keeps running on an empty tank.
  task automatic test_no_dryrun;
    int bad;
    i = 2'b00;
    step(3);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      if ((motor !== 2'b01) || (buzzer !== 2'b01)) bad++;
    end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL no_dry_run_hold: got %0d bad clocks expected 0", bad); end
    tests_run++; if (motor !== 2'b01) begin tests_failed++; $display("FAIL no_dry_motor: got %b expected 01", motor); end
    i = 2'b11;
    step(1);
    $display("[TB] no_dryrun: motor=%b buzzer=%b", motor, buzzer);
  endtask
`endif

  // Reset mid-operation, then debounce restarts from zero.
  task automatic test_midreset;
    rst_n = 1'b0;
    step(1);
    tests_run++; if ({level, motor, buzzer, led} !== 8'h00) begin tests_failed++; $display("FAIL midreset_outputs: got %b expected 00000000", {level, motor, buzzer, led}); end
    rst_n = 1'b1;
    step(1);
    tests_run++; if (level !== 2'b00) begin tests_failed++; $display("FAIL post_reset_debounce: got %b expected 00", level); end
    step(1);
    tests_run++; if (level !== 2'b11) begin tests_failed++; $display("FAIL post_reset_accept: got %b expected 11", level); end
    $display("[TB] midreset: level=%b motor=%b buzzer=%b led=%b", level, motor, buzzer, led);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    i            = 2'b00;
    test_reset();
    test_startup();
    test_fill();
    test_glitch();
    test_hysteresis();
    test_retrigger();
`ifdef ULTRASONIC_DRYRUN_EN
    test_dryrun();
`else
    test_no_dryrun();
`endif
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ultrasonic.md
ULTRASONIC -- requirements
Module: ultrasonic

Interface
REQ-001 Parameter DEBOUNCE, default 2, consecutive equal samples of i required to accept a new level (range 1..15).
REQ-002 Parameter BEEP_CYCLES, default 8, length in clocks of the full-tank buzzer chirp (range 1..255).
REQ-003 Parameter MAX_RUN, default 1000, dry-run timeout in clocks, used only under the configuration macro (range 2..65535).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 i  input  2  raw ultrasonic level code: 00 empty, 01 low, 10 mid, 11 full.
REQ-007 level  output  2  debounced level code, same encoding as i.
REQ-008 motor  output  2  pump status: 00 off, 01 running, 10 fault lockout, 11 never driven.
REQ-009 led  output  2  led[1] = tank full (level==11); led[0] = pump running (motor==01).
REQ-010 buzzer  output  2  00 silent, 01 empty alarm, 10 full chirp, 11 fault alarm.

Function
REQ-011 Each edge samples i into i_q; a stability counter increments while i equals i_q and clears to 1 when it differs.
REQ-012 level SHALL load i on the edge at which i has been identical at DEBOUNCE consecutive sampling edges and differs from level; for DEBOUNCE=2, i changed before edge n appears on level after edge n+1.
REQ-013 Glitches shorter than DEBOUNCE edges SHALL leave level unchanged.
REQ-014 Pump FSM states IDLE and FILL (plus FAULT under macro); motor decodes the state register: IDLE->00, FILL->01, FAULT->10.
REQ-015 IDLE->FILL on the edge after level is 00 or 01; FILL->IDLE on the edge after level is 11; level 10 holds current state (hysteresis).
REQ-016 led SHALL be a combinational decode of registered level and motor.
REQ-017 buzzer is registered, next value by priority: FAULT->11; else beep counter nonzero->10; else level==00->01; else 00.
REQ-018 Beep counter loads BEEP_CYCLES on the edge level changes to 11 from any other value, decrements to 0 each edge, and is cleared when level leaves 11.
REQ-019 Re-entry to level 11 SHALL restart the chirp; remaining at 11 SHALL NOT retrigger it.

Reset
REQ-020 While rst_n is low at a rising edge: level=00, motor=00, buzzer=00, led=00, state IDLE, i_q=00, all counters 0.
REQ-021 Reset asserted mid-operation SHALL take effect on the next edge regardless of state, including FAULT.
REQ-022 After release, normal sampling resumes; debounce restarts from count 0.

Configuration
REQ-023 Macro ULTRASONIC_DRYRUN_EN: when defined, a run counter clears on entering FILL and on every edge level increases, increments otherwise in FILL, and on reaching MAX_RUN moves FSM to FAULT.
REQ-024 With ULTRASONIC_DRYRUN_EN defined, FAULT SHALL be left only by reset; motor=10 and buzzer=11 while in FAULT.
REQ-025 Without ULTRASONIC_DRYRUN_EN, no run counter or FAULT state exists; motor never 10, buzzer never 11.

Verification
REQ-026 Defaults, rst_n low 2 clocks, i=00 -> all outputs 00 during reset; after release level=00, motor=01, buzzer=01, led=01 within 4 clocks.
REQ-027 Pump filling, i steps 01,10,11 each held 5 clocks -> motor stays 01 through 10, goes 00 one edge after level=11; led=10; buzzer=10 for exactly 8 clocks then 00.
REQ-028 level=11, i pulses 10 for 1 clock -> level, motor, buzzer unchanged.
REQ-029 level=11, i=10 held -> level=10, motor stays 00; then i=01 -> motor 01 one edge after level=01.
REQ-030 ULTRASONIC_DRYRUN_EN, MAX_RUN=16, i held 00 -> motor 10, buzzer 11 after 16 clocks in FILL; i=11 keeps FAULT; rst_n low one edge -> all outputs 00.
REQ-031 Without macro, same stimulus as REQ-030 for 100 clocks -> motor stays 01, buzzer stays 01.
